// File: rtl/eth_parser_pkg.sv
// ---------------------------------------------------------------------------
// eth_parser_pkg
//   Shared types for the Ethernet parsing / egress path.
//   - eth_metadata_t : parsed header fields that travel beside a packet.
//   - arb_state_t    : state encoding of the egress round-robin arbiter.
//   - ARB_MAX_PORTS  : largest requester count the arbiter is built for.
// ---------------------------------------------------------------------------
package eth_parser_pkg;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        vlan_present;
        logic [11:0] vlan_id;
    } eth_metadata_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_PORTS = 16;

endpackage

// File: rtl/axis_egress_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority encoder. Searches the request vector
//   upward from (last_grant + 1) mod NUM_PORTS, wrapping, and reports the
//   first requester found.
//   Ports:
//     req        in   NUM_PORTS  request vector
//     last_grant in   GW         most recently served port
//     grant      out  GW         next port to serve (valid when any_req)
//     any_req    out  1          at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int GW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic [GW-1:0]        grant,
    output logic                 any_req
);

    // One extra bit so last_grant + offset never overflows before the wrap.
    localparam int SW = GW + 1;

    logic [SW-1:0] cand;

    // Offsets are walked from farthest to nearest so the nearest requester,
    // which is assigned last, wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        cand    = '0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            cand = {1'b0, last_grant} + SW'(off);
            if (cand >= SW'(NUM_PORTS)) begin
                cand = cand - SW'(NUM_PORTS);
            end
            if (req[cand[GW-1:0]]) begin
                grant = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_egress_arbiter.sv
// ---------------------------------------------------------------------------
// axis_egress_arbiter
//   Packet-granular round-robin arbiter sharing one AXI4-Stream egress path
//   between NUM_PORTS requesters. A grant is held until the granted source's
//   tlast beat is accepted; the granted port's metadata is latched on the
//   grant edge and announced with a one-cycle m_metadata_valid pulse.
//
//   Optional build macro: ARB_PKT_CNT_EN adds pkt_cnt, a free-running 32-bit
//   accepted-packet counter per port.
//
//   Ports:
//     clk, rst (async, active high)
//     s_axis_tdata/tvalid/tready/tlast  per-port ingress streams
//     s_metadata                        per-port parsed metadata
//     m_axis_tdata/tvalid/tready/tlast  egress stream
//     m_metadata, m_metadata_valid      latched metadata + grant pulse
//     grant_idx                         current or last granted port
//     busy                              packet in flight
//     pkt_cnt (ARB_PKT_CNT_EN only)     per-port packet counters
// ---------------------------------------------------------------------------
module axis_egress_arbiter
    import eth_parser_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 4,
    localparam int GW        = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  eth_metadata_t [NUM_PORTS-1:0]    s_metadata,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output eth_metadata_t                    m_metadata,
    output logic                             m_metadata_valid,
    output logic [GW-1:0]                    grant_idx,
    output logic                             busy
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [NUM_PORTS-1:0][31:0]       pkt_cnt
`endif
);

    arb_state_t          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;
    eth_metadata_t       meta_q, meta_d;
    logic                meta_vld_q, meta_vld_d;

    logic [GW-1:0]       pick;
    logic                any_req;
    logic                tlast_accept;
    logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_rr_pick (
        .req        (s_axis_tvalid),
        .last_grant (last_q),
        .grant      (pick),
        .any_req    (any_req)
    );

    // Egress mux: only the granted port is connected, and only while BUSY.
    always_comb begin
        m_axis_tdata  = port_data[grant_q];
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == ARB_BUSY) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign tlast_accept = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        meta_d     = meta_q;
        meta_vld_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (any_req) begin
                state_d    = ARB_BUSY;
                grant_d    = pick;
                meta_d     = s_metadata[pick];
                meta_vld_d = 1'b1;
            end
        end else begin
            // Hold the grant until the packet ends; no preemption even if
            // the granted source stalls.
            if (tlast_accept) begin
                state_d = ARB_IDLE;
                last_d  = grant_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_q     <= GW'(NUM_PORTS - 1);
            meta_q     <= '0;
            meta_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            meta_q     <= meta_d;
            meta_vld_q <= meta_vld_d;
        end
    end

    assign m_metadata       = meta_q;
    assign m_metadata_valid = meta_vld_q;
    assign grant_idx        = grant_q;
    assign busy             = (state_q == ARB_BUSY);

`ifdef ARB_PKT_CNT_EN
    logic [NUM_PORTS-1:0][31:0] cnt_q, cnt_d;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
            assign cnt_d[gi] = cnt_q[gi] +
                ((tlast_accept && (grant_q == GW'(gi))) ? 32'd1 : 32'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_egress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_egress_arbiter
//   Table-driven bench for axis_egress_arbiter (NUM_PORTS=4, DATA_WIDTH=64).
//   Each table row is one clock cycle: inputs driven after the clock edge,
//   outputs compared mid-cycle against hand-computed values. Reset, async
//   mid-packet reset and (with ARB_PKT_CNT_EN) the packet counters are
//   exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_axis_egress_arbiter;
    import eth_parser_pkg::*;

    localparam int DW = 64;
    localparam int NP = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP*DW-1:0]      s_axis_tdata;
    logic [NP-1:0]         s_axis_tvalid;
    logic [NP-1:0]         s_axis_tready;
    logic [NP-1:0]         s_axis_tlast;
    eth_metadata_t [NP-1:0] s_metadata;
    logic [DW-1:0]         m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    eth_metadata_t         m_metadata;
    logic                  m_metadata_valid;
    logic [1:0]            grant_idx;
    logic                  busy;
`ifdef ARB_PKT_CNT_EN
    logic [NP-1:0][31:0]   pkt_cnt;
`endif

    axis_egress_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_metadata       (s_metadata),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_metadata       (m_metadata),
        .m_metadata_valid (m_metadata_valid),
        .grant_idx        (grant_idx),
        .busy             (busy)
`ifdef ARB_PKT_CNT_EN
        ,
        .pkt_cnt          (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic       e_mvalid;
        logic       e_mlast;
        logic [3:0] e_sready;
        int         e_grant;
        logic       e_busy;
        logic       e_mv;
        int         e_meta;   // port whose metadata is expected, -1 = zero
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [3:0] vld, logic [3:0] lst, logic rdy,
                                logic e_mvalid, logic e_mlast, logic [3:0] e_sready,
                                int e_grant, logic e_busy, logic e_mv, int e_meta);
        vec_t v;
        v.vld = vld; v.lst = lst; v.rdy = rdy;
        v.e_mvalid = e_mvalid; v.e_mlast = e_mlast; v.e_sready = e_sready;
        v.e_grant = e_grant; v.e_busy = e_busy; v.e_mv = e_mv; v.e_meta = e_meta;
        return v;
    endfunction

    function automatic eth_metadata_t meta_of(int p);
        eth_metadata_t m;
        m.dst_mac      = 48'h0200_0000_0000 + 48'(p);
        m.src_mac      = 48'h0A0B_0C0D_0E00 + 48'(p);
        m.ethertype    = 16'h0800 + 16'(p);
        m.vlan_present = p[0];
        m.vlan_id      = 12'h100 + 12'(p);
        return m;
    endfunction

    function automatic eth_metadata_t exp_meta(int p);
        eth_metadata_t m;
        m = '0;
        if (p >= 0) m = meta_of(p);
        return m;
    endfunction

    function automatic logic [DW-1:0] data_of(int p, int r);
        return {16'hDA7A, 8'(p), 8'h00, 32'(r)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Metadata inputs are corrupted on cycles where the arbiter is busy, so
    // only a value captured on the grant edge can match the expectation.
    task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic rdy,
                         input int tag, input logic scramble_meta);
        s_axis_tvalid = vld;
        s_axis_tlast  = lst;
        m_axis_tready = rdy;
        for (int p = 0; p < NP; p++) begin
            s_axis_tdata[p*DW +: DW] = data_of(p, tag);
            s_metadata[p] = scramble_meta ? ~meta_of(p) : meta_of(p);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   128'(busy), 128'(0));
        check({tag, "_mvalid"}, 128'(m_axis_tvalid), 128'(0));
        check({tag, "_mlast"},  128'(m_axis_tlast), 128'(0));
        check({tag, "_sready"}, 128'(s_axis_tready), 128'(0));
        check({tag, "_grant"},  128'(grant_idx), 128'(0));
        check({tag, "_mv"},     128'(m_metadata_valid), 128'(0));
        check({tag, "_meta"},   128'(m_metadata), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Port 0 and 2 simultaneous, then port 2 re-granted (incl. 1-beat packet)
        vq.push_back(mk(4'b0101,4'b0000,1, 0,0,4'b0000,0,0,0,-1));
        vq.push_back(mk(4'b0101,4'b0000,1, 1,0,4'b0001,0,1,1, 0));
        vq.push_back(mk(4'b0101,4'b0001,1, 1,1,4'b0001,0,1,0, 0));
        vq.push_back(mk(4'b0100,4'b0000,1, 0,0,4'b0000,0,0,0, 0));
        vq.push_back(mk(4'b0100,4'b0000,1, 1,0,4'b0100,2,1,1, 2));
        vq.push_back(mk(4'b0100,4'b0100,1, 1,1,4'b0100,2,1,0, 2));
        vq.push_back(mk(4'b0100,4'b0000,1, 0,0,4'b0000,2,0,0, 2));
        vq.push_back(mk(4'b0100,4'b0100,1, 1,1,4'b0100,2,1,1, 2));
        vq.push_back(mk(4'b0000,4'b0000,1, 0,0,4'b0000,2,0,0, 2));
        // Port 0 alone, 3-beat packet
        vq.push_back(mk(4'b0001,4'b0000,1, 0,0,4'b0000,2,0,0, 2));
        vq.push_back(mk(4'b0001,4'b0000,1, 1,0,4'b0001,0,1,1, 0));
        vq.push_back(mk(4'b0001,4'b0000,1, 1,0,4'b0001,0,1,0, 0));
        vq.push_back(mk(4'b0001,4'b0001,1, 1,1,4'b0001,0,1,0, 0));
        // Port 3 single beat so that the next round starts at port 0
        vq.push_back(mk(4'b1000,4'b1000,1, 0,0,4'b0000,0,0,0, 0));
        vq.push_back(mk(4'b1000,4'b1000,1, 1,1,4'b1000,3,1,1, 3));
        // All four ports, 2-beat packets: order 0,1,2,3,0 at a 3-cycle period
        vq.push_back(mk(4'b1111,4'b0000,1, 0,0,4'b0000,3,0,0, 3));
        vq.push_back(mk(4'b1111,4'b0000,1, 1,0,4'b0001,0,1,1, 0));
        vq.push_back(mk(4'b1111,4'b0001,1, 1,1,4'b0001,0,1,0, 0));
        vq.push_back(mk(4'b1111,4'b0000,1, 0,0,4'b0000,0,0,0, 0));
        vq.push_back(mk(4'b1111,4'b0000,1, 1,0,4'b0010,1,1,1, 1));
        vq.push_back(mk(4'b1111,4'b0010,1, 1,1,4'b0010,1,1,0, 1));
        vq.push_back(mk(4'b1111,4'b0000,1, 0,0,4'b0000,1,0,0, 1));
        vq.push_back(mk(4'b1111,4'b0000,1, 1,0,4'b0100,2,1,1, 2));
        vq.push_back(mk(4'b1111,4'b0100,1, 1,1,4'b0100,2,1,0, 2));
        vq.push_back(mk(4'b1111,4'b0000,1, 0,0,4'b0000,2,0,0, 2));
        vq.push_back(mk(4'b1111,4'b0000,1, 1,0,4'b1000,3,1,1, 3));
        vq.push_back(mk(4'b1111,4'b1000,1, 1,1,4'b1000,3,1,0, 3));
        vq.push_back(mk(4'b1111,4'b0000,1, 0,0,4'b0000,3,0,0, 3));
        vq.push_back(mk(4'b1111,4'b0000,1, 1,0,4'b0001,0,1,1, 0));
        vq.push_back(mk(4'b1111,4'b0001,1, 1,1,4'b0001,0,1,0, 0));
        // Port 1 under toggling backpressure with port 3 waiting
        vq.push_back(mk(4'b1010,4'b0000,1, 0,0,4'b0000,0,0,0, 0));
        vq.push_back(mk(4'b1010,4'b0000,0, 1,0,4'b0000,1,1,1, 1));
        vq.push_back(mk(4'b1010,4'b0000,1, 1,0,4'b0010,1,1,0, 1));
        vq.push_back(mk(4'b1010,4'b0000,0, 1,0,4'b0000,1,1,0, 1));
        vq.push_back(mk(4'b1010,4'b0000,1, 1,0,4'b0010,1,1,0, 1));
        vq.push_back(mk(4'b1010,4'b0010,0, 1,1,4'b0000,1,1,0, 1));
        vq.push_back(mk(4'b1010,4'b0010,1, 1,1,4'b0010,1,1,0, 1));
        vq.push_back(mk(4'b1000,4'b0000,1, 0,0,4'b0000,1,0,0, 1));
        vq.push_back(mk(4'b1000,4'b1000,1, 1,1,4'b1000,3,1,1, 3));
        vq.push_back(mk(4'b0000,4'b0000,1, 0,0,4'b0000,3,0,0, 3));
        // Port 0 stalls mid-packet while port 1 waits: grant is kept
        vq.push_back(mk(4'b0011,4'b0000,1, 0,0,4'b0000,3,0,0, 3));
        vq.push_back(mk(4'b0011,4'b0000,1, 1,0,4'b0001,0,1,1, 0));
        vq.push_back(mk(4'b0010,4'b0000,1, 0,0,4'b0001,0,1,0, 0));
        vq.push_back(mk(4'b0011,4'b0001,1, 1,1,4'b0001,0,1,0, 0));
        vq.push_back(mk(4'b0010,4'b0000,1, 0,0,4'b0000,0,0,0, 0));
        vq.push_back(mk(4'b0010,4'b0010,1, 1,1,4'b0010,1,1,1, 1));
        vq.push_back(mk(4'b0000,4'b0000,1, 0,0,4'b0000,1,0,0, 1));

        // Reset state, with every port requesting to prove outputs are gated
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        $display("reset: busy=%0d grant=%0d mvalid=%0d", busy, grant_idx, m_axis_tvalid);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].vld, vq[i].lst, vq[i].rdy, i, vq[i].e_busy);
            #2;
            check($sformatf("row%0d_mvalid", i), 128'(m_axis_tvalid), 128'(vq[i].e_mvalid));
            check($sformatf("row%0d_mlast", i),  128'(m_axis_tlast),  128'(vq[i].e_mlast));
            check($sformatf("row%0d_sready", i), 128'(s_axis_tready), 128'(vq[i].e_sready));
            check($sformatf("row%0d_grant", i),  128'(grant_idx),     128'(vq[i].e_grant));
            check($sformatf("row%0d_busy", i),   128'(busy),          128'(vq[i].e_busy));
            check($sformatf("row%0d_mv", i),     128'(m_metadata_valid), 128'(vq[i].e_mv));
            check($sformatf("row%0d_meta", i),   128'(m_metadata),    128'(exp_meta(vq[i].e_meta)));
            if (vq[i].e_mvalid)
                check($sformatf("row%0d_tdata", i), 128'(m_axis_tdata), 128'(data_of(vq[i].e_grant, i)));
            $display("row %0d: vld=%b rdy=%0d grant=%0d busy=%0d mvalid=%0d mlast=%0d sready=%b mv=%0d",
                     i, vq[i].vld, vq[i].rdy, grant_idx, busy, m_axis_tvalid, m_axis_tlast,
                     s_axis_tready, m_metadata_valid);
            @(posedge clk);
            #1;
        end

        // Async reset on beat 2 of a 4-beat packet from port 2
        drive(4'b0100, 4'b0000, 1'b1, 100, 1'b0);
        #2;
        check("mid_idle_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0000, 1'b1, 101, 1'b1);
        #1;
        check("mid_beat1_grant", 128'(grant_idx), 128'(2));
        check("mid_beat1_mv", 128'(m_metadata_valid), 128'(1));
        @(posedge clk);
        #1;
        drive(4'b0100, 4'b0000, 1'b1, 102, 1'b1);
        #1;
        check("mid_beat2_busy", 128'(busy), 128'(1));
        check("mid_beat2_mvalid", 128'(m_axis_tvalid), 128'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        $display("mid-packet reset: busy=%0d mvalid=%0d grant=%0d", busy, m_axis_tvalid, grant_idx);
        rst = 1'b0;
        drive(4'b0101, 4'b0000, 1'b1, 103, 1'b0);
        @(posedge clk);
        #1;
        drive(4'b0101, 4'b0000, 1'b1, 104, 1'b1);
        #1;
        check("post_rst_grant", 128'(grant_idx), 128'(0));
        check("post_rst_busy", 128'(busy), 128'(1));
        check("post_rst_mv", 128'(m_metadata_valid), 128'(1));
        check("post_rst_meta", 128'(m_metadata), 128'(meta_of(0)));
        check("post_rst_tdata", 128'(m_axis_tdata), 128'(data_of(0, 104)));
        $display("post-reset grant: grant=%0d busy=%0d", grant_idx, busy);

`ifdef ARB_PKT_CNT_EN
        // Five single-beat packets from port 2 after a clean reset
        drive(4'b0000, 4'b0000, 1'b1, 200, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int p = 0; p < NP; p++)
            check($sformatf("cnt_reset%0d", p), 128'(pkt_cnt[p]), 128'(0));
        drive(4'b0100, 4'b0100, 1'b1, 201, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        drive(4'b0000, 4'b0000, 1'b1, 202, 1'b0);
        #1;
        for (int p = 0; p < NP; p++)
            check($sformatf("cnt_port%0d", p), 128'(pkt_cnt[p]), 128'((p == 2) ? 5 : 0));
        $display("pkt_cnt: %0d %0d %0d %0d", pkt_cnt[0], pkt_cnt[1], pkt_cnt[2], pkt_cnt[3]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_egress_arbiter.md
# axis_egress_arbiter

Packet-granular round-robin arbiter that shares the single AXI4-Stream egress path between NUM_PORTS internal requesters. It sits in front of the egress pass-through stage. It grants one source at a time and holds the grant until that source's tlast beat is accepted. It also forwards the granted source's parsed Ethernet metadata on a sideband that pulses once per packet.

## Interface
Parameters:
- DATA_WIDTH, 64, AXI-Stream data width in bits
- NUM_PORTS, 4, number of requesting streams (2..16)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_metadata  in  NUM_PORTS x eth_metadata_t  per-port metadata, packed array; must be stable while that port's tvalid is high on its first beat
- m_axis_tdata  out  DATA_WIDTH  egress data
- m_axis_tvalid  out  1  egress valid
- m_axis_tready  in  1  egress ready
- m_axis_tlast  out  1  egress last
- m_metadata  out  eth_metadata_t  metadata of the current or most recent granted packet
- m_metadata_valid  out  1  one-cycle pulse when a grant is issued
- grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port
- busy  out  1  high while a packet is in flight

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - All s_axis_tready are 0; m_axis_tvalid is 0.
  - If any s_axis_tvalid is high, select the first requesting port, searching upward from (last_grant+1) mod NUM_PORTS with wrap.
  - On that edge: register grant_idx, latch s_metadata[grant], set m_metadata_valid for one cycle, and go to BUSY.
- BUSY: combinational mux of the granted port.
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast come from the granted port.
  - s_axis_tready[grant] = m_axis_tready; all other ready bits are 0.
  - A tlast handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast) returns the FSM to IDLE and updates last_grant = grant_idx.
- A granted port that drops tvalid mid-packet keeps the grant; the arbiter never preempts.
- Non-requesting ports are skipped; a single requester is re-granted on consecutive packets.
- s_metadata sampling uses only the value present on the grant edge.

## Timing
- Reset values: state IDLE, last_grant = NUM_PORTS-1 (so port 0 has first priority), grant_idx 0, busy 0, m_metadata 0, m_metadata_valid 0. All ready and valid outputs are 0.
- Arbitration latency: a request seen in IDLE at cycle N gives busy=1 and first beat presentable at cycle N+1.
- Packet of L beats with m_axis_tready held at 1: L BUSY cycles, then 1 IDLE bubble cycle. Sustained period is L+1 cycles.
- Simultaneous requests: exactly one grant is issued, following round-robin order.
- Backpressure: m_axis_tready=0 holds the beat. Data and valid stay stable because the source obeys AXI rules.
- Reset asserted mid-packet: outputs return to reset values immediately (async). The partial packet is abandoned, and upstream recovery is a system-level concern.
- Single-beat packet (tlast on first beat) takes 1 BUSY cycle.

## Configuration
- ARB_PKT_CNT_EN defined:
  - Adds output pkt_cnt (NUM_PORTS x 32 bits).
  - Per-port counter increments on each accepted tlast beat from that port.
  - Counters wrap at 2^32 and reset to 0.
- ARB_PKT_CNT_EN undefined:
  - The port and the counters are absent.
  - Datapath behaviour is identical.

## Structure
- eth_parser_pkg holds eth_metadata_t (existing type).
- eth_parser_pkg also gains the FSM enum arb_state_t (ARB_IDLE, ARB_BUSY) and the constant ARB_MAX_PORTS = 16.
- One sub-module: rr_pick. It is a combinational round-robin priority encoder (inputs: request vector and last_grant; outputs: next grant index and any_req), instantiated once.

## Test plan
- Port 0 alone sends a 3-beat packet with ready=1 -> m_metadata_valid pulses once, 3 output beats with tlast on beat 3, then busy=0.
- Ports 0 and 2 request simultaneously after reset -> port 0 is granted first, then port 2. With only port 2 still requesting, port 2 is re-granted.
- All 4 ports continuously send 2-beat packets -> grant order 0,1,2,3,0 and a 3-cycle period per packet.
- Port 1 packet with m_axis_tready toggled every cycle, and port 3 requesting during it -> no interleaving, s_axis_tready[3]=0 until port 1's tlast is accepted.
- rst pulsed mid-packet on beat 2 of 4 -> busy=0 and m_axis_tvalid=0 in the same cycle. The next grant goes to port 0 if it is requesting.
- With ARB_PKT_CNT_EN, 5 packets sent from port 2 -> pkt_cnt[2]=5 and all other counters 0.
